// File: rtl/rv_pkg.sv
// Shared RV64I decode definitions: opcodes, opclass/format encodings, funct3 values.
// Also holds the ID/EX entry layout; INST_DECODE_ILLEGAL_EN adds an illegal flag to it.
package rv_pkg;

   localparam int XLEN_DEFAULT = 64;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   localparam logic [2:0] F3_LB  = 3'd0, F3_LH  = 3'd1, F3_LW  = 3'd2, F3_LD = 3'd3;
   localparam logic [2:0] F3_LBU = 3'd4, F3_LHU = 3'd5, F3_LWU = 3'd6;
   localparam logic [2:0] F3_SB  = 3'd0, F3_SH  = 3'd1, F3_SW  = 3'd2, F3_SD = 3'd3;
   localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4;
   localparam logic [2:0] F3_BGE = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;

   // OC_NONE is zero so an all-zero entry is a bubble.
   typedef enum logic [3:0] {
      OC_NONE    = 4'd0,
      OC_LUI     = 4'd1,
      OC_AUIPC   = 4'd2,
      OC_JAL     = 4'd3,
      OC_JALR    = 4'd4,
      OC_BRANCH  = 4'd5,
      OC_LOAD    = 4'd6,
      OC_STORE   = 4'd7,
      OC_OPIMM   = 4'd8,
      OC_OP      = 4'd9,
      OC_OPIMM32 = 4'd10,
      OC_OP32    = 4'd11,
      OC_SYSTEM  = 4'd12
   } opclass_e;

   typedef enum logic [2:0] {
      FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
   } fmt_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      opclass_e   opclass;
      logic [2:0] funct3;
      logic       funct7b5;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       is_branch;
      logic       alu_src_imm;
`ifdef INST_DECODE_ILLEGAL_EN
      logic       illegal;
`endif
   } id_ex_t;

   function automatic opclass_e opclass_of(input logic [6:0] opc);
      opclass_e oc;
      case (opc)
         OPC_LUI:     oc = OC_LUI;
         OPC_AUIPC:   oc = OC_AUIPC;
         OPC_JAL:     oc = OC_JAL;
         OPC_JALR:    oc = OC_JALR;
         OPC_BRANCH:  oc = OC_BRANCH;
         OPC_LOAD:    oc = OC_LOAD;
         OPC_STORE:   oc = OC_STORE;
         OPC_OPIMM:   oc = OC_OPIMM;
         OPC_OP:      oc = OC_OP;
         OPC_OPIMM32: oc = OC_OPIMM32;
         OPC_OP32:    oc = OC_OP32;
         OPC_SYSTEM:  oc = OC_SYSTEM;
         default:     oc = OC_NONE;
      endcase
      return oc;
   endfunction

   function automatic fmt_e fmt_of(input opclass_e oc);
      fmt_e f;
      case (oc)
         OC_LUI, OC_AUIPC:                        f = FMT_U;
         OC_JAL:                                  f = FMT_J;
         OC_BRANCH:                               f = FMT_B;
         OC_STORE:                                f = FMT_S;
         OC_OP, OC_OP32:                          f = FMT_R;
         OC_JALR, OC_LOAD, OC_OPIMM, OC_OPIMM32,
         OC_SYSTEM:                               f = FMT_I;
         default:                                 f = FMT_NONE;
      endcase
      return f;
   endfunction

   function automatic logic f3_reserved(input opclass_e oc, input logic [2:0] f3);
      logic rsv;
      case (oc)
         OC_LOAD:   rsv = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU});
         OC_STORE:  rsv = !(f3 inside {F3_SB, F3_SH, F3_SW, F3_SD});
         OC_BRANCH: rsv = !(f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
         default:   rsv = 1'b0;
      endcase
      return rsv;
   endfunction

endpackage

// File: rtl/inst_decode_if.sv
// Fetch-to-decode and decode-to-EX signal bundle; illegal/illegal_seen exist
// only when INST_DECODE_ILLEGAL_EN is defined.
interface inst_decode_if import rv_pkg::*; #(parameter int XLEN = XLEN_DEFAULT);

   logic [31:0]     inst;
   logic            take_branch;
   logic            stall_in;
   logic            stall_out;
   logic            valid;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm;
   opclass_e        opclass;
   logic [2:0]      funct3;
   logic            funct7b5;
   logic            reg_write;
   logic            mem_read;
   logic            mem_write;
   logic            is_branch;
   logic            alu_src_imm;
`ifdef INST_DECODE_ILLEGAL_EN
   logic            illegal;
   logic            illegal_seen;
`endif

   modport master (
      output inst, take_branch, stall_in,
      input  stall_out, valid, rs1, rs2, rd, imm, opclass, funct3, funct7b5,
             reg_write, mem_read, mem_write, is_branch, alu_src_imm
`ifdef INST_DECODE_ILLEGAL_EN
      , input illegal, illegal_seen
`endif
   );

   modport slave (
      input  inst, take_branch, stall_in,
      output stall_out, valid, rs1, rs2, rd, imm, opclass, funct3, funct7b5,
             reg_write, mem_read, mem_write, is_branch, alu_src_imm
`ifdef INST_DECODE_ILLEGAL_EN
      , output illegal, illegal_seen
`endif
   );

endinterface

// File: rtl/inst_decode_imm_gen.sv
// Combinational immediate generator: picks the I/S/B/U/J layout from the opcode
// and sign-extends from inst[31]; R-type and unknown opcodes yield zero.
module imm_gen import rv_pkg::*; #(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm
);

   fmt_e fmt;

   assign fmt = fmt_of(opclass_of(inst[6:0]));

   always_comb begin
      imm = '0;
      case (fmt)
         FMT_I: imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
         FMT_S: imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B: imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U: imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
         FMT_J: imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/inst_decode.sv
// RV64I decode stage: field split, ID/EX register, load-use stall and branch flush.
// Define INST_DECODE_ILLEGAL_EN to add the illegal / illegal_seen outputs.
module inst_decode import rv_pkg::*; #(
   parameter int FLUSH_DEPTH = 2,
   parameter int XLEN        = XLEN_DEFAULT
) (
   input  logic         CLK,
   input  logic         reset,
   inst_decode_if.slave dif
);

   localparam int CW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
   localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_DEPTH - 1);

   id_ex_t          dec;
   opclass_e        oc_dec;
   fmt_e            fmt_dec;
   logic            uses_rs1;
   logic            uses_rs2;
   logic            uses_rd;
   logic [XLEN-1:0] imm_dec;
   logic            load_use;

   id_ex_t          id_q,        id_d;
   logic [XLEN-1:0] imm_q,       imm_d;
   logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
`ifdef INST_DECODE_ILLEGAL_EN
   logic            illegal_seen_q, illegal_seen_d;
`endif

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst (dif.inst),
      .imm  (imm_dec)
   );

   always_comb begin
      // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
      dec      = '0;
      oc_dec   = opclass_of(dif.inst[6:0]);
      fmt_dec  = fmt_of(oc_dec);
      uses_rs1 = fmt_dec inside {FMT_R, FMT_I, FMT_S, FMT_B};
      uses_rs2 = fmt_dec inside {FMT_R, FMT_S, FMT_B};
      uses_rd  = fmt_dec inside {FMT_R, FMT_I, FMT_U, FMT_J};

      dec.valid       = 1'b1;
      dec.opclass     = oc_dec;
      dec.funct3      = dif.inst[14:12];
      dec.funct7b5    = dif.inst[30];
      dec.rs1         = uses_rs1 ? dif.inst[19:15] : 5'd0;
      dec.rs2         = uses_rs2 ? dif.inst[24:20] : 5'd0;
      dec.rd          = uses_rd  ? dif.inst[11:7]  : 5'd0;
      dec.reg_write   = uses_rd && (dif.inst[11:7] != 5'd0);
      dec.mem_read    = (oc_dec == OC_LOAD);
      dec.mem_write   = (oc_dec == OC_STORE);
      dec.is_branch   = (oc_dec == OC_BRANCH);
      dec.alu_src_imm = fmt_dec inside {FMT_I, FMT_S, FMT_U};
`ifdef INST_DECODE_ILLEGAL_EN
      dec.illegal = (oc_dec == OC_NONE) || (dif.inst[1:0] != 2'b11) ||
                    f3_reserved(oc_dec, dif.inst[14:12]);
      if (dec.illegal) begin
         dec.reg_write = 1'b0;
         dec.mem_read  = 1'b0;
         dec.mem_write = 1'b0;
      end
`endif
   end

   // Load in ID/EX whose destination feeds the instruction now waiting in decode.
   always_comb begin
      load_use = id_q.valid && id_q.mem_read && (id_q.rd != 5'd0) &&
                 ((uses_rs1 && (id_q.rd == dec.rs1)) || (uses_rs2 && (id_q.rd == dec.rs2)));
   end

   assign dif.stall_out = load_use | dif.stall_in;

   always_comb begin
      id_d        = id_q;
      imm_d       = imm_q;
      flush_cnt_d = flush_cnt_q;
`ifdef INST_DECODE_ILLEGAL_EN
      illegal_seen_d = illegal_seen_q;
`endif
      if (dif.take_branch) begin
         id_d        = '0;
         imm_d       = '0;
         flush_cnt_d = FLUSH_LOAD;
      end else if (flush_cnt_q != '0) begin
         id_d        = '0;
         imm_d       = '0;
         flush_cnt_d = flush_cnt_q - CW'(1);
      end else if (dif.stall_in) begin
         id_d  = id_q;
         imm_d = imm_q;
      end else if (load_use) begin
         id_d  = '0;
         imm_d = '0;
      end else begin
         id_d  = dec;
         imm_d = imm_dec;
`ifdef INST_DECODE_ILLEGAL_EN
         illegal_seen_d = illegal_seen_q | dec.illegal;
`endif
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         id_q        <= '0;
         imm_q       <= '0;
         flush_cnt_q <= '0;
`ifdef INST_DECODE_ILLEGAL_EN
         illegal_seen_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         id_q        <= id_d;
         imm_q       <= imm_d;
         flush_cnt_q <= flush_cnt_d;
`ifdef INST_DECODE_ILLEGAL_EN
         illegal_seen_q <= illegal_seen_d;
`endif
      end
   end

   assign dif.valid       = id_q.valid;
   assign dif.rs1         = id_q.rs1;
   assign dif.rs2         = id_q.rs2;
   assign dif.rd          = id_q.rd;
   assign dif.imm         = imm_q;
   assign dif.opclass     = id_q.opclass;
   assign dif.funct3      = id_q.funct3;
   assign dif.funct7b5    = id_q.funct7b5;
   assign dif.reg_write   = id_q.reg_write;
   assign dif.mem_read    = id_q.mem_read;
   assign dif.mem_write   = id_q.mem_write;
   assign dif.is_branch   = id_q.is_branch;
   assign dif.alu_src_imm = id_q.alu_src_imm;
`ifdef INST_DECODE_ILLEGAL_EN
   assign dif.illegal      = id_q.illegal;
   assign dif.illegal_seen = illegal_seen_q;
`endif

endmodule

// File: tb/tb_inst_decode.sv
// Bench for inst_decode: directed literal checks plus randomized traffic compared
// every cycle against an arithmetic reference model of the decode rules.
module tb_inst_decode;
   import rv_pkg::*;

   localparam int FD = 2;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] ADDI = 32'h0050_0093;
   localparam logic [31:0] LD   = 32'h0000_B103;
   localparam logic [31:0] ADD  = 32'h0011_01B3;
   localparam logic [31:0] BEQ  = 32'hFE00_0EE3;

   logic CLK   = 1'b0;
   logic reset = 1'b0;
   always #5 CLK = ~CLK;

   inst_decode_if #(.XLEN(64)) dif();

   inst_decode #(.FLUSH_DEPTH(FD), .XLEN(64)) dut (
      .CLK   (CLK),
      .reset (reset),
      .dif   (dif)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit        valid;
      bit [4:0]  rs1, rs2, rd;
      bit [63:0] imm;
      bit [3:0]  oc;
      bit [2:0]  f3;
      bit        f7;
      bit        rw, mr, mw, br, ai;
      bit        ill;
   } exp_t;

   function automatic exp_t bubble();
      exp_t e = '{default: 0};
      e.oc = OC_NONE;
      return e;
   endfunction

   // Reference decode: immediates are built as signed offsets from weighted bit groups.
   function automatic exp_t model_decode(input logic [31:0] w);
      exp_t   e = '{default: 0};
      byte    fmt;
      longint v;
      e.valid = 1'b1;
      e.f3    = w[14:12];
      e.f7    = w[30];
      case (w[6:0])
         OPC_LUI:     begin e.oc = OC_LUI;     fmt = "U"; end
         OPC_AUIPC:   begin e.oc = OC_AUIPC;   fmt = "U"; end
         OPC_JAL:     begin e.oc = OC_JAL;     fmt = "J"; end
         OPC_JALR:    begin e.oc = OC_JALR;    fmt = "I"; end
         OPC_BRANCH:  begin e.oc = OC_BRANCH;  fmt = "B"; end
         OPC_LOAD:    begin e.oc = OC_LOAD;    fmt = "I"; end
         OPC_STORE:   begin e.oc = OC_STORE;   fmt = "S"; end
         OPC_OPIMM:   begin e.oc = OC_OPIMM;   fmt = "I"; end
         OPC_OP:      begin e.oc = OC_OP;      fmt = "R"; end
         OPC_OPIMM32: begin e.oc = OC_OPIMM32; fmt = "I"; end
         OPC_OP32:    begin e.oc = OC_OP32;    fmt = "R"; end
         OPC_SYSTEM:  begin e.oc = OC_SYSTEM;  fmt = "I"; end
         default:     begin e.oc = OC_NONE;    fmt = "-"; end
      endcase
      if (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") e.rd  = w[11:7];
      if (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B") e.rs1 = w[19:15];
      if (fmt == "R" || fmt == "S" || fmt == "B")               e.rs2 = w[24:20];
      case (fmt)
         "I": v = longint'(w[30:20]) - longint'(w[31]) * 2048;
         "S": v = longint'(w[11:7]) + longint'(w[30:25]) * 32 - longint'(w[31]) * 2048;
         "B": v = longint'(w[11:8]) * 2 + longint'(w[30:25]) * 32 + longint'(w[7]) * 2048
                  - longint'(w[31]) * 4096;
         "U": v = longint'(w[30:12]) * 4096 - longint'(w[31]) * 64'sd2147483648;
         "J": v = longint'(w[30:21]) * 2 + longint'(w[20]) * 2048 + longint'(w[19:12]) * 4096
                  - longint'(w[31]) * 1048576;
         default: v = 0;
      endcase
      e.imm = v;
      e.rw  = (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") && (w[11:7] != 0);
      e.mr  = (e.oc == OC_LOAD);
      e.mw  = (e.oc == OC_STORE);
      e.br  = (e.oc == OC_BRANCH);
      e.ai  = (fmt == "I" || fmt == "S" || fmt == "U");
`ifdef INST_DECODE_ILLEGAL_EN
      e.ill = (e.oc == OC_NONE) ||
              (e.oc == OC_LOAD   && w[14:12] == 3'd7) ||
              (e.oc == OC_STORE  && w[14:12] >= 3'd4) ||
              (e.oc == OC_BRANCH && (w[14:12] == 3'd2 || w[14:12] == 3'd3));
      if (e.ill) begin e.rw = 0; e.mr = 0; e.mw = 0; end
`endif
      return e;
   endfunction

   // Unused source fields are already zero in the decoded view, and rd is nonzero here.
   function automatic bit model_hazard(input exp_t cur, input logic [31:0] w);
      exp_t d = model_decode(w);
      return cur.valid && cur.mr && (cur.rd != 0) && (d.rs1 == cur.rd || d.rs2 == cur.rd);
   endfunction

   exp_t m = '{default: 0};
   int   flush_left = 0;
   bit   m_seen = 0;

   always @(posedge CLK or negedge reset) begin
      if (!reset) begin
         m = bubble(); flush_left = 0; m_seen = 0;
      end else if (dif.take_branch) begin
         m = bubble(); flush_left = FD - 1;
      end else if (flush_left > 0) begin
         m = bubble(); flush_left--;
      end else if (dif.stall_in) begin
         m = m;
      end else if (model_hazard(m, dif.inst)) begin
         m = bubble();
      end else begin
         m = model_decode(dif.inst);
         m_seen = m_seen | m.ill;
      end
   end

   always @(negedge CLK) begin
      check("valid",       dif.valid,       m.valid);
      check("rs1",         dif.rs1,         m.rs1);
      check("rs2",         dif.rs2,         m.rs2);
      check("rd",          dif.rd,          m.rd);
      check("imm",         dif.imm,         m.imm);
      check("opclass",     dif.opclass,     m.oc);
      check("funct3",      dif.funct3,      m.f3);
      check("funct7b5",    dif.funct7b5,    m.f7);
      check("reg_write",   dif.reg_write,   m.rw);
      check("mem_read",    dif.mem_read,    m.mr);
      check("mem_write",   dif.mem_write,   m.mw);
      check("is_branch",   dif.is_branch,   m.br);
      check("alu_src_imm", dif.alu_src_imm, m.ai);
      check("stall_out",   dif.stall_out,   model_hazard(m, dif.inst) | dif.stall_in);
`ifdef INST_DECODE_ILLEGAL_EN
      check("illegal",      dif.illegal,      m.ill);
      check("illegal_seen", dif.illegal_seen, m_seen);
`endif
   end

   task automatic present(input logic [31:0] w, input logic tb, input logic si);
      @(posedge CLK);
      #2;
      dif.inst        = w;
      dif.take_branch = tb;
      dif.stall_in    = si;
   endtask

   function automatic logic [31:0] mk_addi(input logic [4:0] rd, input logic [11:0] iv);
      return {iv, 5'd0, 3'b000, rd, OPC_OPIMM};
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w = $urandom;
      logic [6:0]  ops [14] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                                OPC_STORE, OPC_OPIMM, OPC_OP, OPC_OPIMM32, OPC_OP32,
                                OPC_SYSTEM, OPC_LOAD, OPC_LOAD};
      int k = $urandom_range(0, 15);
      if (k < 14) w[6:0] = ops[k];
      else if (k == 14) w[1:0] = 2'($urandom_range(0, 2));
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      return w;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      logic hold;
      dif.inst = NOP; dif.take_branch = 1'b0; dif.stall_in = 1'b0;

      repeat (3) @(negedge CLK);
      check("rst_valid",     dif.valid,     0);
      check("rst_stall_out", dif.stall_out, 0);
      check("rst_imm",       dif.imm,       0);
      check("rst_opclass",   dif.opclass,   OC_NONE);

      @(posedge CLK); #2;
      reset = 1'b1; dif.inst = ADDI;
      present(NOP, 0, 0);
      @(negedge CLK);
      check("addi_valid", dif.valid,       1);
      check("addi_rd",    dif.rd,          1);
      check("addi_rs1",   dif.rs1,         0);
      check("addi_imm",   dif.imm,         5);
      check("addi_oc",    dif.opclass,     OC_OPIMM);
      check("addi_rw",    dif.reg_write,   1);
      check("addi_ai",    dif.alu_src_imm, 1);

      present(LD, 0, 0);
      present(ADD, 0, 0);
      @(negedge CLK);
      check("ld_mem_read",  dif.mem_read,  1);
      check("ld_rd",        dif.rd,        2);
      check("lu_stall_on",  dif.stall_out, 1);
      present(ADD, 0, 0);
      @(negedge CLK);
      check("lu_bubble",    dif.valid,     0);
      check("lu_stall_off", dif.stall_out, 0);
      present(NOP, 0, 0);
      @(negedge CLK);
      check("add_valid", dif.valid,   1);
      check("add_rs1",   dif.rs1,     2);
      check("add_rs2",   dif.rs2,     1);
      check("add_rd",    dif.rd,      3);
      check("add_oc",    dif.opclass, OC_OP);

      present(BEQ, 0, 0);
      present(NOP, 0, 0);
      @(negedge CLK);
      check("beq_imm", dif.imm,       64'hFFFF_FFFF_FFFF_FFFC);
      check("beq_br",  dif.is_branch, 1);
      check("beq_rd",  dif.rd,        0);
      check("beq_rw",  dif.reg_write, 0);

      present(mk_addi(5'd1, 12'd1), 1, 0);
      present(mk_addi(5'd2, 12'd2), 0, 0);
      @(negedge CLK);
      check("flush_b0", dif.valid, 0);
      present(mk_addi(5'd3, 12'd3), 0, 0);
      @(negedge CLK);
      check("flush_b1", dif.valid, 0);
      present(NOP, 0, 0);
      @(negedge CLK);
      check("flush_resume_valid", dif.valid, 1);
      check("flush_resume_rd",    dif.rd,    3);

      present(mk_addi(5'd1, 12'd1), 1, 0);
      present(mk_addi(5'd2, 12'd2), 1, 0);
      present(mk_addi(5'd3, 12'd3), 0, 0);
      @(negedge CLK);
      check("reflush_b1", dif.valid, 0);
      present(mk_addi(5'd4, 12'd4), 0, 0);
      @(negedge CLK);
      check("reflush_b2", dif.valid, 0);
      present(NOP, 0, 0);
      @(negedge CLK);
      check("reflush_resume_rd", dif.rd, 4);

      present(mk_addi(5'd5, 12'd7), 0, 0);
      present(mk_addi(5'd6, 12'd1), 0, 1);
      @(negedge CLK);
      check("stall_pre_rd", dif.rd, 5);
      for (int i = 0; i < 2; i++) begin
         present(mk_addi(5'd6, 12'd1), 0, 1);
         @(negedge CLK);
         check("stall_hold_rd",  dif.rd,        5);
         check("stall_hold_imm", dif.imm,       7);
         check("stall_out_hi",   dif.stall_out, 1);
      end
      present(mk_addi(5'd6, 12'd1), 1, 1);
      @(negedge CLK);
      check("stall_hold3_rd", dif.rd, 5);
      present(mk_addi(5'd6, 12'd1), 0, 0);
      @(negedge CLK);
      check("stall_branch_bubble", dif.valid, 0);

      present(32'h0000_0000, 0, 0);
      present(NOP, 0, 0);
      @(negedge CLK);
      check("zero_valid", dif.valid,     1);
      check("zero_oc",    dif.opclass,   OC_NONE);
      check("zero_rw",    dif.reg_write, 0);
`ifdef INST_DECODE_ILLEGAL_EN
      check("ill_flag", dif.illegal,      1);
      check("ill_seen", dif.illegal_seen, 1);
      present(ADDI, 0, 0);
      @(negedge CLK);
      @(negedge CLK);
      check("ill_clear",       dif.illegal,      0);
      check("ill_seen_sticky", dif.illegal_seen, 1);
`endif

      for (int c = 0; c < 3000; c++) begin
         @(negedge CLK);
         hold = dif.stall_out;
         @(posedge CLK);
         #2;
         if (c == 1500) begin
            #1 reset = 1'b0;
            #1;
            check("midrst_valid", dif.valid, 0);
            check("midrst_imm",   dif.imm,   0);
`ifdef INST_DECODE_ILLEGAL_EN
            check("midrst_seen",  dif.illegal_seen, 0);
`endif
            @(posedge CLK);
            @(posedge CLK);
            #2 reset = 1'b1;
            hold = 1'b0;
         end
         if (!hold) dif.inst = rand_inst();
         dif.take_branch = ($urandom_range(0, 9) == 0);
         dif.stall_in    = ($urandom_range(0, 6) == 0);
      end

      @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
